// File: rtl/debounce_multi_if.sv
// Signal bundle between the raw button pins and the debouncer, plus per-channel FSM state for observation.
// btn_in is a free-running level; every output is either a level or a one-cycle pulse, with no valid/ready handshake.
interface debounce_multi_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0]   btn_in;
  logic [N_CH-1:0]   btn_level;
  logic [N_CH-1:0]   btn_rise;
  logic [N_CH-1:0]   btn_fall;
  logic [N_CH-1:0]   btn_long;
  logic [N_CH-1:0]   btn_repeat;
  // Two bits per channel: 0 = released, 1 = pressed, 2 = held.
  logic [2*N_CH-1:0] fsm_state;

  modport master (
    output btn_in,
    input  btn_level,
    input  btn_rise,
    input  btn_fall,
    input  btn_long,
    input  btn_repeat,
    input  fsm_state
  );

  modport slave (
    input  btn_in,
    output btn_level,
    output btn_rise,
    output btn_fall,
    output btn_long,
    output btn_repeat,
    output fsm_state
  );
endinterface

// File: rtl/debounce_multi.sv
// Multi-channel push-button debouncer: per-channel synchroniser, stability counter,
// press/release pulses and a press FSM producing long-press and auto-repeat pulses.
module debounce_multi #(
  parameter int N_CH            = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int LONG_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000,
  parameter int ACTIVE_LOW      = 0
) (
  input logic             clk,
  input logic             rst_n,
  debounce_multi_if.slave bus
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam int RW = (REPEAT_CYCLES > 0) ? $clog2(REPEAT_CYCLES + 1) : 1;

  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] H_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [RW-1:0] R_LAST = RW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
  localparam logic          INV    = (ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    PRESSED  = 2'd1,
    HELD     = 2'd2
  } state_t;

  logic [N_CH-1:0]   level_v;
  logic [N_CH-1:0]   rise_v;
  logic [N_CH-1:0]   fall_v;
  logic [N_CH-1:0]   long_v;
  logic [N_CH-1:0]   repeat_v;
  logic [2*N_CH-1:0] state_v;

  assign bus.btn_level  = level_v;
  assign bus.btn_rise   = rise_v;
  assign bus.btn_fall   = fall_v;
  assign bus.btn_long   = long_v;
  assign bus.btn_repeat = repeat_v;
  assign bus.fsm_state  = state_v;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [DW-1:0]          dcnt_q;
    logic [HW-1:0]          hold_q;
    logic [RW-1:0]          rcnt_q;
    logic                   level_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   long_q;
    logic                   repeat_q;
    state_t                 state_q;

    logic raw;
    logic s;
    logic flip;
    logic go_high;
    logic go_low;

    // Inversion ahead of the first flop keeps "pressed" = 1 everywhere downstream.
    assign raw     = bus.btn_in[i] ^ INV;
    assign s       = sync_q[SYNC_STAGES-1];
    assign flip    = (s != level_q) && (dcnt_q == D_LAST);
    assign go_high = flip && s;
    assign go_low  = flip && !s;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      end
    end

    // Count consecutive disagreeing cycles; any agreement restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dcnt_q  <= '0;
        level_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        rise_q <= go_high;
        fall_q <= go_low;
        if (s == level_q) begin
          dcnt_q <= '0;
        end else if (dcnt_q == D_LAST) begin
          level_q <= s;
          dcnt_q  <= '0;
        end else begin
          dcnt_q <= dcnt_q + DW'(1);
        end
      end
    end

    // A release landing on an expiring long/repeat count wins: go_low is checked first.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q  <= RELEASED;
        hold_q   <= '0;
        rcnt_q   <= '0;
        long_q   <= 1'b0;
        repeat_q <= 1'b0;
      end else begin
        long_q   <= 1'b0;
        repeat_q <= 1'b0;
        if (go_low) begin
          state_q <= RELEASED;
          hold_q  <= '0;
          rcnt_q  <= '0;
        end else begin
          case (state_q)
            RELEASED: begin
              if (go_high) begin
                state_q <= PRESSED;
                hold_q  <= '0;
                rcnt_q  <= '0;
              end
            end
            PRESSED: begin
              if (hold_q == H_LAST) begin
                long_q  <= 1'b1;
                state_q <= HELD;
                rcnt_q  <= '0;
              end else begin
                hold_q <= hold_q + HW'(1);
              end
            end
            HELD: begin
              if (REPEAT_CYCLES > 0) begin
                if (rcnt_q == R_LAST) begin
                  repeat_q <= 1'b1;
                  rcnt_q   <= '0;
                end else begin
                  rcnt_q <= rcnt_q + RW'(1);
                end
              end
            end
            default: begin
              state_q <= RELEASED;
              hold_q  <= '0;
              rcnt_q  <= '0;
            end
          endcase
        end
      end
    end

    assign level_v[i]          = level_q;
    assign rise_v[i]           = rise_q;
    assign fall_v[i]           = fall_q;
    assign long_v[i]           = long_q;
    assign repeat_v[i]         = repeat_q;
    assign state_v[2*i +: 2]   = state_q;
  end

endmodule
